square_op_scheduler: RTL and testbench
======================================

Name: square_op_scheduler

Overview:
- Arbitrates grid-square draw and erase requests from up to NUM_REQ game-logic requesters.
- Sequences the shared 20x20 square engine (start/done handshake) one square at a time.
- Forwards the engine's pixel stream to the 160x120 VGA adapter write port, so only one requester ever owns the VGA plot path.
- Sits between game FSMs (tower placement, enemy movement, cursor) and the square engine / VGA adapter.

Parameters:
- NUM_REQ, 3, number of requesters (1..4)
- GRID_W, 8, grid columns; valid X is 0..GRID_W-1
- GRID_H, 6, grid rows; valid Y is 0..GRID_H-1
- TIMEOUT, 1023, max cycles in RUN waiting for sq_done before abort

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request, held until ack
- req_X  in  4*NUM_REQ  packed grid column per requester (requester i at [4i+3:4i])
- req_Y  in  4*NUM_REQ  packed grid row per requester
- req_mode  in  2*NUM_REQ  packed op: 0 = erase (background), 1..3 = sprite index
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- err  out  1  one-cycle pulse coincident with ack when the op was rejected or timed out
- busy  out  1  high in any state other than IDLE
- sq_start  out  1  one-cycle start pulse to square engine
- sq_X  out  4  latched grid column
- sq_Y  out  4  latched grid row
- sq_mode  out  2  op currently issued to engine
- sq_done  in  1  engine completion pulse
- sq_pix_valid  in  1  engine pixel valid
- sq_x  in  8  engine pixel x
- sq_y  in  7  engine pixel y
- sq_colour  in  9  engine pixel colour
- vga_x  out  8  registered pixel x to VGA
- vga_y  out  7  registered pixel y to VGA
- vga_colour  out  9  registered colour to VGA
- vga_plot  out  1  registered write enable to VGA

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, rr pointer=0, all outputs 0, latched X/Y/mode=0, timeout counter=0. Reset mid-RUN abandons the op silently, with no ack.
- States: IDLE, START, RUN, ACK.
- IDLE: if any req bit is high, grant the first asserted index at or after rr pointer (round-robin, wrapping). Latch its X/Y/mode into sq_X/sq_Y/sq_mode and go to START next cycle.
  - If latched X>=GRID_W or Y>=GRID_H, go to ACK with err flagged instead; the engine is never started.
- START: sq_start=1 for exactly this cycle. Clear timeout counter. Go to RUN.
- RUN: count cycles each clock.
  - On sq_done: go to ACK.
  - If counter reaches TIMEOUT before sq_done: go to ACK with err flagged.
  - sq_done seen in any state other than RUN is ignored.
- ACK: ack[grant]=1 and err as flagged, for one cycle. rr pointer = grant+1 mod NUM_REQ. Go to IDLE.
- Requester contract:
  - req must stay high until ack and drop by the cycle after ack.
  - req dropped before grant is a withdrawal.
  - req changes after grant are ignored; the X/Y/mode latched at grant are used.
- Latency: req high in IDLE at cycle n gives sq_start at n+1. Fastest ack is the cycle after sq_done. A rejected request acks at n+1.
- Pixel path:
  - vga_plot <= sq_pix_valid && state==RUN.
  - vga_x, vga_y, vga_colour <= sq_x, sq_y, sq_colour every cycle.
  - All pixel outputs have one-cycle registered latency.
  - Pixels outside RUN never produce a plot.
- Simultaneous requests resolve by rr pointer only; no starvation. Worst-case wait is (NUM_REQ-1) ops.
- busy=0 only in IDLE.

Optional Feature:
- Macro: ERASE_BEFORE_DRAW_EN.
- Defined: a granted op with mode!=0 runs two engine passes, then one ack.
  - Pass 1: sq_mode=0 (erase): START, RUN.
  - Pass 2: sq_mode=original mode: START, RUN, then ACK.
  - A timeout in either pass aborts straight to ACK with err.
  - Mode-0 requests run a single pass.
- Undefined: every op is a single pass with the requested mode.

Test Plan:
- Single request: req[0]=1, X=2, Y=1, mode=1; engine asserts sq_done 400 cycles after start.
  - Expect sq_start at n+1 with sq_X=2, sq_Y=1, sq_mode=1.
  - Expect ack[0] one cycle after sq_done, err=0.
- Round-robin: req=3'b111 held, rr=0.
  - Expect grant order 0,1,2; after reasserting all, expect 0,1,2 again.
  - Exactly one ack per op, no overlap of sq_start while busy.
- Out of range: X=8 (GRID_W=8).
  - Expect no sq_start; ack and err at n+1.
  - Y=6 gives the same result.
- Timeout: engine never pulses sq_done.
  - Expect ack and err exactly TIMEOUT cycles after entering RUN; next request is served normally.
- Pixel gating: sq_pix_valid=1 with sq_x=45, sq_y=30, sq_colour=9'h1FF, in IDLE and then in RUN.
  - Expect vga_plot=0 in IDLE.
  - Expect vga_plot=1 with vga_x=45, vga_y=30, vga_colour=9'h1FF one cycle after the RUN sample.
- Async reset mid-RUN: resetn low mid-op.
  - Expect all outputs 0 immediately, with no ack.
  - With ERASE_BEFORE_DRAW_EN, a mode=2 request shows two sq_start pulses (sq_mode 0 then 2) and a single ack.

Source files
------------

// File: rtl/square_op_scheduler.sv
// Purpose: round-robin arbiter that sequences the shared 20x20 square engine and owns the VGA plot path.
// Latency: req in IDLE -> sq_start next cycle; ack the cycle after sq_done; rejected op acks next cycle.
// Backpressure: one op at a time; other requesters hold req until their own ack (worst wait NUM_REQ-1 ops).
//
// Ports: clk/resetn (async active-low); req/req_X/req_Y/req_mode packed per requester, ack/err completion;
//        busy; sq_start/sq_X/sq_Y/sq_mode/sq_done + sq_pix_* engine side; vga_x/vga_y/vga_colour/vga_plot.
// Optional: define ERASE_BEFORE_DRAW_EN to run an erase pass before every sprite (mode!=0) draw.
module square_op_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int GRID_W  = 8,
  parameter int GRID_H  = 6,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   req_X,
  input  logic [4*NUM_REQ-1:0]   req_Y,
  input  logic [2*NUM_REQ-1:0]   req_mode,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   err,
  output logic                   busy,
  output logic                   sq_start,
  output logic [3:0]             sq_X,
  output logic [3:0]             sq_Y,
  output logic [1:0]             sq_mode,
  input  logic                   sq_done,
  input  logic                   sq_pix_valid,
  input  logic [7:0]             sq_x,
  input  logic [6:0]             sq_y,
  input  logic [8:0]             sq_colour,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [8:0]             vga_colour,
  output logic                   vga_plot
);

  typedef enum logic [1:0] {IDLE, START, RUN, ACK} state_t;

  localparam int         CW   = $clog2(TIMEOUT + 1);
  localparam logic [1:0] LAST = 2'(NUM_REQ - 1);

  state_t        state;
  logic [1:0]    rr;
  logic [1:0]    grant;
  logic [CW-1:0] tcnt;

  // Arbitration / operand select
  logic          found;
  logic [1:0]    sel;
  logic [1:0]    cand;
  int            idx;
  logic [3:0]    req4;
  logic [15:0]   req_x16;
  logic [15:0]   req_y16;
  logic [7:0]    req_m8;
  logic [3:0]    sel_x;
  logic [3:0]    sel_y;
  logic [1:0]    sel_mode;
  logic          in_range;

`ifdef ERASE_BEFORE_DRAW_EN
  logic          draw_pending;
  logic [1:0]    draw_mode;
`endif

  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] g);
    logic [3:0] w;
    w = 4'b0001 << g;
    return w[NUM_REQ-1:0];
  endfunction

  // Operand vectors are zero-padded to the 4-requester maximum so a 2-bit
  // grant index always selects in range.
  always_comb begin
    req4    = 4'(req);
    req_x16 = 16'(req_X);
    req_y16 = 16'(req_Y);
    req_m8  = 8'(req_mode);
    found   = 1'b0;
    sel     = 2'd0;
    cand    = 2'd0;
    idx     = 0;
    // First asserted requester at or after rr, wrapping.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = 2'(idx);
      if (!found && req4[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    sel_x    = req_x16[{sel, 2'b00} +: 4];
    sel_y    = req_y16[{sel, 2'b00} +: 4];
    sel_mode = req_m8[{sel, 1'b0} +: 2];
    in_range = ({1'b0, sel_x} < 5'(GRID_W)) && ({1'b0, sel_y} < 5'(GRID_H));
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      rr         <= 2'd0;
      grant      <= 2'd0;
      tcnt       <= '0;
      ack        <= '0;
      err        <= 1'b0;
      sq_start   <= 1'b0;
      sq_X       <= 4'd0;
      sq_Y       <= 4'd0;
      sq_mode    <= 2'd0;
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 9'd0;
      vga_plot   <= 1'b0;
`ifdef ERASE_BEFORE_DRAW_EN
      draw_pending <= 1'b0;
      draw_mode    <= 2'd0;
`endif
    end else begin
      // Pulse outputs default low; set only on the transition that needs them.
      sq_start   <= 1'b0;
      ack        <= '0;
      err        <= 1'b0;
      vga_plot   <= sq_pix_valid && (state == RUN);
      vga_x      <= sq_x;
      vga_y      <= sq_y;
      vga_colour <= sq_colour;

      case (state)
        IDLE: begin
          if (found) begin
            grant <= sel;
            sq_X  <= sel_x;
            sq_Y  <= sel_y;
            if (!in_range) begin
              // Off-grid square: reject without touching the engine.
              sq_mode <= sel_mode;
              ack     <= onehot(sel);
              err     <= 1'b1;
              state   <= ACK;
            end else begin
`ifdef ERASE_BEFORE_DRAW_EN
              // Sprite draws first clear the square to background.
              draw_pending <= (sel_mode != 2'd0);
              draw_mode    <= sel_mode;
              sq_mode      <= 2'd0;
`else
              sq_mode      <= sel_mode;
`endif
              sq_start <= 1'b1;
              state    <= START;
            end
          end
        end

        START: begin
          tcnt  <= '0;
          state <= RUN;
        end

        RUN: begin
          if (sq_done) begin
`ifdef ERASE_BEFORE_DRAW_EN
            if (draw_pending) begin
              draw_pending <= 1'b0;
              sq_mode      <= draw_mode;
              sq_start     <= 1'b1;
              state        <= START;
            end else
`endif
            begin
              ack   <= onehot(grant);
              state <= ACK;
            end
          end else if (tcnt == CW'(TIMEOUT - 1)) begin
            // Ack lands exactly TIMEOUT cycles after entering RUN.
            ack   <= onehot(grant);
            err   <= 1'b1;
            state <= ACK;
`ifdef ERASE_BEFORE_DRAW_EN
            draw_pending <= 1'b0;
`endif
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        ACK: begin
          rr    <= (grant == LAST) ? 2'd0 : grant + 2'd1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_square_op_scheduler.sv
module tb_square_op_scheduler;

  localparam int NUM_REQ = 3;
  localparam int TIMEOUT = 1023;

  logic         clk = 1'b0;
  logic         resetn;
  logic [2:0]   req;
  logic [11:0]  req_X;
  logic [11:0]  req_Y;
  logic [5:0]   req_mode;
  logic [2:0]   ack;
  logic         err;
  logic         busy;
  logic         sq_start;
  logic [3:0]   sq_X;
  logic [3:0]   sq_Y;
  logic [1:0]   sq_mode;
  logic         sq_done;
  logic         sq_pix_valid;
  logic [7:0]   sq_x;
  logic [6:0]   sq_y;
  logic [8:0]   sq_colour;
  logic [7:0]   vga_x;
  logic [6:0]   vga_y;
  logic [8:0]   vga_colour;
  logic         vga_plot;

  int checks = 0;
  int errors = 0;

  square_op_scheduler #(
    .NUM_REQ(NUM_REQ), .GRID_W(8), .GRID_H(6), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req(req), .req_X(req_X), .req_Y(req_Y), .req_mode(req_mode),
    .ack(ack), .err(err), .busy(busy),
    .sq_start(sq_start), .sq_X(sq_X), .sq_Y(sq_Y), .sq_mode(sq_mode),
    .sq_done(sq_done), .sq_pix_valid(sq_pix_valid),
    .sq_x(sq_x), .sq_y(sq_y), .sq_colour(sq_colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int g, input logic [3:0] x, input logic [3:0] y, input logic [1:0] m);
    req_X[4*g +: 4]    = x;
    req_Y[4*g +: 4]    = y;
    req_mode[2*g +: 2] = m;
    req[g]             = 1'b1;
  endtask

  // Requester g is expected to win the next grant; engine answers after wait_cycles in RUN.
  task automatic run_op(input int g, input logic [3:0] x, input logic [3:0] y,
                        input logic [1:0] m, input int wait_cycles);
    tick();
    check("start_pulse", 32'(sq_start), 32'd1);
    check("start_x", 32'(sq_X), 32'(x));
    check("start_y", 32'(sq_Y), 32'(y));
`ifdef ERASE_BEFORE_DRAW_EN
    if (m != 2'd0) begin
      check("erase_mode", 32'(sq_mode), 32'd0);
      tick();
      sq_done = 1'b1;
      tick();
      sq_done = 1'b0;
      check("draw_start", 32'(sq_start), 32'd1);
      check("draw_mode", 32'(sq_mode), 32'(m));
      check("no_ack_between_passes", 32'(ack), 32'd0);
    end else begin
      check("start_mode", 32'(sq_mode), 32'(m));
    end
`else
    check("start_mode", 32'(sq_mode), 32'(m));
`endif
    tick();
    check("run_start_low", 32'(sq_start), 32'd0);
    repeat (wait_cycles) tick();
    check("ack_before_done", 32'(ack), 32'd0);
    sq_done = 1'b1;
    tick();
    sq_done = 1'b0;
    check("ack_grant", 32'(ack), 32'(1) << g);
    check("ack_err", 32'(err), 32'd0);
    check("ack_busy", 32'(busy), 32'd1);
    req[g] = 1'b0;
    tick();
    check("post_ack_clear", 32'(ack), 32'd0);
    check("post_ack_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; req = '0; req_X = '0; req_Y = '0; req_mode = '0;
    sq_done = 1'b0; sq_pix_valid = 1'b0; sq_x = '0; sq_y = '0; sq_colour = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_start", 32'(sq_start), 32'd0);
    check("rst_sqxy", {24'd0, sq_X, sq_Y}, 32'd0);
    check("rst_plot", 32'(vga_plot), 32'd0);
    resetn = 1'b1;

    // Pixels presented in IDLE never plot, but data still registers.
    sq_pix_valid = 1'b1; sq_x = 8'd45; sq_y = 7'd30; sq_colour = 9'h1FF;
    tick();
    check("idle_plot", 32'(vga_plot), 32'd0);
    check("idle_vga_x", 32'(vga_x), 32'd45);
    check("idle_vga_y", 32'(vga_y), 32'd30);
    check("idle_vga_colour", 32'(vga_colour), 32'h1FF);
    sq_pix_valid = 1'b0;

    // Single request, engine finishes ~400 cycles after start.
    set_req(0, 4'd2, 4'd1, 2'd1);
    run_op(0, 4'd2, 4'd1, 2'd1, 398);

    // X out of range on requester 1 (rr now 1).
    set_req(1, 4'd8, 4'd0, 2'd1);
    tick();
    check("oobx_no_start", 32'(sq_start), 32'd0);
    check("oobx_ack", 32'(ack), 32'b010);
    check("oobx_err", 32'(err), 32'd1);
    check("oobx_latched_x", 32'(sq_X), 32'd8);
    req[1] = 1'b0;
    tick();
    check("oobx_ack_clear", 32'(ack), 32'd0);
    check("oobx_err_clear", 32'(err), 32'd0);

    // Y out of range on requester 2 (rr now 2).
    set_req(2, 4'd0, 4'd6, 2'd3);
    tick();
    check("ooby_no_start", 32'(sq_start), 32'd0);
    check("ooby_ack", 32'(ack), 32'b100);
    check("ooby_err", 32'(err), 32'd1);
    req[2] = 1'b0;
    tick();
    check("ooby_idle", 32'(busy), 32'd0);

    // Round-robin with all three held, rr back at 0: order 0,1,2 twice.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3; i++) set_req(i, 4'(i + 1), 4'(i + 2), 2'(i + 1));
      for (int i = 0; i < 3; i++) run_op(i, 4'(i + 1), 4'(i + 2), 2'(i + 1), 3);
    end

    // Timeout: engine never completes. Also pixel gating inside RUN.
    set_req(0, 4'd7, 4'd5, 2'd0);
    tick();
    check("to_start", 32'(sq_start), 32'd1);
    tick();
    sq_pix_valid = 1'b1; sq_x = 8'd45; sq_y = 7'd30; sq_colour = 9'h1FF;
    tick();
    check("run_plot", 32'(vga_plot), 32'd1);
    check("run_vga_x", 32'(vga_x), 32'd45);
    check("run_vga_y", 32'(vga_y), 32'd30);
    check("run_vga_colour", 32'(vga_colour), 32'h1FF);
    sq_pix_valid = 1'b0; sq_x = 8'd0; sq_y = 7'd0; sq_colour = 9'd0;
    repeat (TIMEOUT - 2) tick();
    check("to_no_ack_early", 32'(ack), 32'd0);
    check("to_busy", 32'(busy), 32'd1);
    tick();
    check("to_ack", 32'(ack), 32'b001);
    check("to_err", 32'(err), 32'd1);
    req[0] = 1'b0;
    tick();
    check("to_idle", 32'(busy), 32'd0);

    // A stray sq_done in IDLE is ignored.
    sq_done = 1'b1;
    tick();
    sq_done = 1'b0;
    check("idle_done_busy", 32'(busy), 32'd0);
    check("idle_done_ack", 32'(ack), 32'd0);

    // Next request after the timeout is served normally (rr now 1).
    set_req(1, 4'd7, 4'd5, 2'd2);
    run_op(1, 4'd7, 4'd5, 2'd2, 5);

    // Asynchronous reset in the middle of RUN.
    set_req(2, 4'd3, 4'd4, 2'd0);
    tick();
    tick();
    sq_pix_valid = 1'b1; sq_x = 8'd12; sq_y = 7'd9; sq_colour = 9'h0A5;
    tick();
    check("pre_rst_plot", 32'(vga_plot), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_plot", 32'(vga_plot), 32'd0);
    check("arst_vga", {8'd0, vga_x, vga_y, vga_colour}, 32'd0);
    check("arst_sq", {22'd0, sq_start, sq_X, sq_Y, sq_mode}, 32'd0);
    check("arst_ack", {28'd0, ack, err}, 32'd0);
    repeat (3) tick();
    check("arst_no_ack", 32'(ack), 32'd0);
    req = '0; sq_pix_valid = 1'b0;
    resetn = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);

    // rr pointer returned to 0: requester 0 beats requester 2.
    set_req(0, 4'd1, 4'd1, 2'd0);
    set_req(2, 4'd5, 4'd2, 2'd0);
    run_op(0, 4'd1, 4'd1, 2'd0, 2);
    run_op(2, 4'd5, 4'd2, 2'd0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
